// File: rtl/elastic_fifo_buffer.sv
// rtl/elastic_fifo_buffer.sv - multi-entry elastic buffer with flush, occupancy and almost-full status
// Registered-only handshake: ready_in and data_out never see ready_out or data_in combinationally.
module elastic_fifo_buffer #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign ready_in    = (cnt != CW'(DEPTH));
    assign valid_out   = (cnt != '0);
    assign data_out    = mem[rd_ptr];
    assign count       = cnt;
    assign almost_full = (cnt >= CW'(AF_LEVEL));

    assign push = valid_in & ready_in;
    assign pop  = valid_out & ready_out;

    // Storage is never cleared; a push concurrent with flush/reset is dropped.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_elastic_fifo_buffer.sv
// tb/tb_elastic_fifo_buffer.sv - self-checking bench for elastic_fifo_buffer against a queue model
module tb_elastic_fifo_buffer;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          valid_in;
    logic          ready_in;
    logic [W-1:0]  data_in;
    logic          valid_out;
    logic          ready_out;
    logic [W-1:0]  data_out;
    logic [CW-1:0] count;
    logic          almost_full;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  model_q[$];
    logic [W-1:0]  got[$];
    logic [W-1:0]  sent[$];
    logic          hold_pend = 1'b0;
    logic [W-1:0]  hold_data = '0;
    logic          last_push = 1'b0;
    logic          stall_q = 1'b0;
    logic [W-1:0]  stall_d = '0;

    elastic_fifo_buffer #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .data_in    (data_in),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .count      (count),
        .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            assert (count <= CW'(D)) else $error("count above depth: %0d", count);
            assert (!(valid_in && ready_in && count == CW'(D))) else $error("push while full");
            assert (!(valid_out && ready_out && count == '0)) else $error("pop while empty");
            if (stall_q && !flush)
                assert (valid_in && data_in == stall_d) else $error("upstream dropped stalled item");
        end
        stall_q <= !reset && valid_in && !ready_in;
        stall_d <= data_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, compare against the model at negedge, advance the model after the edge.
    task automatic cycle(input logic r, input logic f, input logic vi, input logic [W-1:0] di,
                         input logic ro);
        int           sz;
        logic         do_push;
        logic         do_pop;
        logic [W-1:0] out_d;
        reset = r; flush = f; valid_in = vi; data_in = di; ready_out = ro;
        @(negedge clk);
        sz = model_q.size();
        check("ready_in", 32'(ready_in), 32'(sz != D));
        check("valid_out", 32'(valid_out), 32'(sz != 0));
        check("count", 32'(count), 32'(sz));
        check("almost_full", 32'(almost_full), 32'(sz >= AF));
        if (sz != 0) check("data_out", 32'(data_out), 32'(model_q[0]));
        if (hold_pend) check("hold_data", 32'(data_out), 32'(hold_data));
        out_d     = data_out;
        do_pop    = (sz != 0) && ro;
        do_push   = vi && (sz != D);
        hold_pend = (sz != 0) && !ro && !r && !f;
        hold_data = data_out;
        @(posedge clk);
        if (r || f) begin
            model_q.delete();
        end else begin
            if (do_pop) begin
                got.push_back(out_d);
                void'(model_q.pop_front());
            end
            if (do_push) begin
                model_q.push_back(di);
                sent.push_back(di);
            end
        end
        last_push = do_push && !r && !f;
        #1;
    endtask

    task automatic check_seq(input string tag, input logic [W-1:0] exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(tag, 32'(got[i]), 32'(exp[i]));
        got.delete();
        sent.delete();
    endtask

    task automatic drain();
        for (int k = 0; k < 3 * D && model_q.size() != 0; k++)
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("drained", 32'(count), 32'd0);
    endtask

    initial begin
        logic [W-1:0] exp_q[$];
        logic         pushed;
        logic         vi;
        logic         ro;
        logic         pvi;
        logic [W-1:0] di;
        logic [W-1:0] pdi;

        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
        @(posedge clk); #1;

        // Reset held with valid_in high stores nothing
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_ready_in", 32'(ready_in), 32'd1);
        check("rst_af", 32'(almost_full), 32'd0);

        // Fill, hold fifth item, drain in order
        cycle(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
        check("fill_af2", 32'(almost_full), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
        check("fill_af3", 32'(almost_full), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 8'h44, 1'b0);
        check("fill_full_ready", 32'(ready_in), 32'd0);
        check("fill_full_count", 32'(count), 32'd4);
        cycle(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        check("fill_held_count", 32'(count), 32'd4);
        pushed = 1'b0;
        for (int k = 0; k < 12 && !(pushed && model_q.size() == 0); k++) begin
            cycle(1'b0, 1'b0, !pushed, 8'h55, 1'b1);
            if (last_push) pushed = 1'b1;
        end
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        check_seq("fill_order", exp_q);

        // Streaming at full throughput
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b1, W'(i), 1'b1);
            check("stream_cnt", 32'(count), 32'd1);
        end
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(W'(i));
        check_seq("stream_order", exp_q);

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, W'(8'h61 + i), 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'h65, 1'b1);
        check("fullpop_count", 32'(count), 32'd3);
        check("fullpop_ready", 32'(ready_in), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 8'h65, 1'b0);
        check("fullpop_refill", 32'(count), 32'd4);
        drain();
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        check_seq("fullpop_order", exp_q);

        // Flush beats concurrent push and pop
        cycle(1'b0, 1'b0, 1'b1, 8'hA0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'hB0, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid_out", 32'(valid_out), 32'd0);
        check("flush_ready_in", 32'(ready_in), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 8'hC0, 1'b0);
        check("flush_next_valid", 32'(valid_out), 32'd1);
        check("flush_next_data", 32'(data_out), 32'hC0);
        drain();
        exp_q = '{8'hC0};
        check_seq("flush_order", exp_q);

        // Random backpressure starting from two stored items
        cycle(1'b0, 1'b0, 1'b1, 8'hD0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hD1, 1'b0);
        pvi = 1'b0; pdi = '0;
        repeat (50) begin
            if (pvi && !last_push) begin
                vi = 1'b1; di = pdi;
            end else begin
                vi = 1'($urandom_range(0, 1)); di = W'($urandom);
            end
            ro = 1'($urandom_range(0, 1));
            cycle(1'b0, 1'b0, vi, di, ro);
            pvi = vi; pdi = di;
        end
        for (int k = 0; k < 12 && (model_q.size() != 0 || (pvi && !last_push)); k++) begin
            vi = pvi && !last_push;
            cycle(1'b0, 1'b0, vi, pdi, 1'b1);
            pvi = vi;
        end
        exp_q = sent;
        check_seq("random_order", exp_q);

        // Reset mid-stream discards contents
        cycle(1'b0, 1'b0, 1'b1, 8'hE0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hE1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'hE2, 1'b1);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_valid_out", 32'(valid_out), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elastic_fifo_buffer.md
Name: elastic_fifo_buffer

Overview:
Parametrised multi-entry successor to the single-entry pipeline skid stage, used between out-of-order pipeline stages such as decode→rename and rename→dispatch. It accepts one item per cycle and delivers one item per cycle at full throughput, with no combinational path from ready_out to ready_in or from data_in to data_out. It adds a synchronous flush for branch-mispredict recovery, plus occupancy and almost-full status outputs.

Parameters:
WIDTH, 32, payload width in bits (≥1)
DEPTH, 4, number of storage entries (≥2, need not be a power of two)
AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
CW, $clog2(DEPTH+1), count width (derived, do not override)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous discard of all stored entries
valid_in  in  1  upstream item valid
ready_in  out  1  buffer can accept an item this cycle
data_in  in  WIDTH  upstream payload
valid_out  out  1  head item valid
ready_out  in  1  downstream accepts head item
data_out  out  WIDTH  head payload
count  out  CW  current occupancy, 0..DEPTH
almost_full  out  1  count ≥ AF_LEVEL

Behaviour:
- Storage: circular array mem[DEPTH], write pointer wr_ptr, read pointer rd_ptr, occupancy register cnt.
- Pointer wrap is explicit: ptr == DEPTH-1 → 0, otherwise ptr+1. No modulo-2^n assumption.
- push = valid_in & ready_in; pop = valid_out & ready_out.
- ready_in = (cnt != DEPTH). It is a function of registered state only and never depends on ready_out.
- valid_out = (cnt != 0). data_out = mem[rd_ptr], read combinationally from registered storage and never from data_in.
- count = cnt; almost_full = (cnt ≥ AF_LEVEL).
- Latency: an item pushed at edge N appears on data_out/valid_out after edge N. There is no same-cycle bypass, so minimum latency is 1 cycle.
- push only: mem[wr_ptr] ← data_in, wr_ptr advances, cnt+1.
- pop only: rd_ptr advances, cnt-1.
- push and pop together (only possible when 0 < cnt < DEPTH): both pointers advance and cnt is unchanged. Sustained throughput is 1 item/cycle.
- Full (cnt == DEPTH): ready_in = 0 even if ready_out = 1 in the same cycle; the item is accepted on the following cycle. Valid_in items are not lost; upstream must hold them.
- Empty (cnt == 0): valid_out = 0, and data_out is don't-care (holds the stale mem value).
- Hold rule: while valid_out & !ready_out, data_out and valid_out stay stable until accepted.
- flush: at the edge, wr_ptr, rd_ptr and cnt go to 0; mem is not cleared. flush has priority over push and pop in the same cycle, so a concurrent push is dropped and a concurrent pop is still seen as a handshake by downstream but has no effect. One cycle after flush: valid_out = 0, ready_in = 1.
- reset: same effect as flush and has priority over it. Reset values: valid_out = 0, ready_in = 1, count = 0, almost_full = (AF_LEVEL == 0 ? 1 : 0) = 0. Reset asserted mid-stream discards all contents.
- Upstream protocol assumption enforced by assertion only: valid_in may not drop, and data_in may not change, while valid_in & !ready_in.
- Assertions in bench: cnt ≤ DEPTH; never push when cnt == DEPTH; never pop when cnt == 0.

Test Plan:
1. Reset with WIDTH=8, DEPTH=4 → valid_out=0, ready_in=1, count=0, almost_full=0. Hold reset 3 cycles with valid_in=1 → nothing stored.
2. Fill: push 0x11,0x22,0x33,0x44 with ready_out=0 → count 1,2,3,4; almost_full rises at count=3; ready_in=0 at count=4. Fifth item 0x55 is held by upstream. Raising ready_out drains 0x11..0x44 in order, then 0x55.
3. Streaming: valid_in=1 and ready_out=1 every cycle, data 0..19 → output 0..19 in order, one per cycle after 1-cycle latency. count stays 1 throughout, and pointers wrap ≥4 times.
4. Full with simultaneous pop: at count=4 assert ready_out=1 and valid_in=1 → the pop occurs, ready_in=0 that cycle, count=3. The next cycle the push is accepted and count returns to 4.
5. Flush mid-operation: count=3 (0xA0,0xA1,0xA2), assert flush with valid_in=1 data 0xB0 and ready_out=1 → next cycle count=0, valid_out=0, 0xB0 not stored. A subsequent push of 0xC0 appears at data_out next cycle.
6. Backpressure hold: count=2, toggle ready_out 0/1 randomly for 50 cycles with random valid_in → scoreboard sees exact in-order delivery, and data_out is stable whenever valid_out & !ready_out.
